// File: rtl/debug_pin_scheduler.sv
// Round-robin scheduler that shares one debug pin between NUM_REQ requesters.
// Each grant sends a START/DATA(MSB first)/STOP frame; the idle pin carries a heartbeat.
module debug_pin_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = 8,
    parameter int DIV_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*CODE_W-1:0] code,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      hb_en,
    input  logic [DIV_W-1:0]          hb_div,
    output logic                      dbg_out,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [1:0]                dbg_state
);

    localparam int BIT_W = $clog2(CODE_W + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     ptr, ptr_n, sel, grant_id_n;
    logic                found;
    logic [CODE_W-1:0]   shreg, shreg_n;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0]    hb_cnt, hb_cnt_n;
    logic                hb, hb_n, dbg_n;
    logic [NUM_REQ-1:0]  ack_n;

    // Round-robin pick: first set request at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // Heartbeat only advances in IDLE; during a frame counter and hb stay frozen.
    always_comb begin
        hb_n     = hb;
        hb_cnt_n = hb_cnt;
        if (state == IDLE) begin
            if (!hb_en) begin
                hb_cnt_n = '0;
            end else if (hb_cnt >= hb_div) begin
                hb_n     = ~hb;
                hb_cnt_n = '0;
            end else begin
                hb_cnt_n = hb_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        grant_id_n = grant_id;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        ack_n      = '0;
        dbg_n      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n    = START;
                    ptr_n      = (int'(sel) == NUM_REQ - 1) ? '0 : sel + ID_W'(1);
                    grant_id_n = sel;
                    shreg_n    = code[int'(sel)*CODE_W +: CODE_W];
                    ack_n      = NUM_REQ'(1) << sel;
                    dbg_n      = 1'b1;
                end else begin
                    dbg_n = hb_n;
                end
            end
            START: begin
                state_n   = DATA;
                bit_cnt_n = '0;
                dbg_n     = shreg[CODE_W-1];
            end
            DATA: begin
                if (bit_cnt == BIT_W'(CODE_W - 1)) begin
                    state_n = STOP;
                    dbg_n   = 1'b0;
                end else begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                    shreg_n   = shreg << 1;
                    dbg_n     = shreg_n[CODE_W-1];
                end
            end
            STOP: begin
                state_n = IDLE;
                dbg_n   = hb;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            hb_cnt   <= '0;
            hb       <= 1'b0;
            ack      <= '0;
            dbg_out  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            grant_id <= grant_id_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            hb_cnt   <= hb_cnt_n;
            hb       <= hb_n;
            ack      <= ack_n;
            dbg_out  <= dbg_n;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_debug_pin_scheduler.sv
// Scoreboard bench: the driver pushes the expected {ack,busy,grant_id,dbg_out}
// for every cycle it drives; a negedge monitor pops and compares.
module tb_debug_pin_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] code;
    logic [3:0]  ack;
    logic        hb_en;
    logic [15:0] hb_div;
    logic        dbg_out;
    logic        busy;
    logic [1:0]  grant_id;
    logic [1:0]  dbg_state;

    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  codes[4] = '{8'h81, 8'h42, 8'h24, 8'h18};

    debug_pin_scheduler #(.NUM_REQ(4), .CODE_W(8), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .code(code), .ack(ack),
        .hb_en(hb_en), .hb_div(hb_div), .dbg_out(dbg_out), .busy(busy),
        .grant_id(grant_id), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic [3:0] a, input logic b,
                                      input logic [1:0] g, input logic d);
        return {a, b, g, d};
    endfunction

    // Expectation for the current cycle; inputs set beforehand act on the next edge.
    task automatic cycle(input logic [7:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input int id, input logic [7:0] cv);
        cycle(mk(4'(1 << id), 1'b1, 2'(id), 1'b1));
        for (int k = 7; k >= 0; k--) cycle(mk(4'd0, 1'b1, 2'(id), cv[k]));
        cycle(mk(4'd0, 1'b1, 2'(id), 1'b0));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e, a;
            e = exp_q.pop_front();
            a = {ack, busy, grant_id, dbg_out};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_check #%0d t=%0t: got ack=%b busy=%b gid=%0d dbg=%b, want ack=%b busy=%b gid=%0d dbg=%b",
                         checks, $time, a[7:4], a[3], a[2:1], a[0], e[7:4], e[3], e[2:1], e[0]);
            end
        end
    end

    initial begin
        logic [8:0] pat3;
        logic [3:0] pat1;
        logic [7:0] a5;
        logic [5:0] frz;
        pat3 = 9'b000111000;
        pat1 = 4'b1010;
        a5   = 8'hA5;
        frz  = 6'b011110;
        rst_n = 1'b0; req = '0; code = '0; hb_en = 1'b0; hb_div = '0;
        repeat (2) @(posedge clk);
        #2;
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));
        rst_n = 1'b1;
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));

        // Heartbeat with half-period 3, then every cycle, then held
        hb_en = 1'b1; hb_div = 16'd2;
        for (int i = 8; i >= 0; i--) cycle(mk(4'd0, 1'b0, 2'd0, pat3[i]));
        hb_div = 16'd0;
        for (int i = 3; i >= 0; i--) cycle(mk(4'd0, 1'b0, 2'd0, pat1[i]));
        hb_en = 1'b0;
        repeat (3) cycle(mk(4'd0, 1'b0, 2'd0, 1'b1));

        // Single frame from requester 1; code change and req[2] pulse mid-frame
        code = {8'h00, 8'h00, 8'hA5, 8'h00};
        req  = 4'b0010;
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b1));
        req  = 4'b0000;
        code = '1;
        cycle(mk(4'b0010, 1'b1, 2'd1, 1'b1));
        for (int k = 7; k >= 0; k--) begin
            req = (k == 5) ? 4'b0100 : 4'b0000;
            cycle(mk(4'd0, 1'b1, 2'd1, a5[k]));
        end
        req = 4'b0000;
        cycle(mk(4'd0, 1'b1, 2'd1, 1'b0));
        cycle(mk(4'd0, 1'b0, 2'd1, 1'b1));
        cycle(mk(4'd0, 1'b0, 2'd1, 1'b1));

        // Reset, then round robin with all requests held
        rst_n = 1'b0;
        cycle(mk(4'd0, 1'b0, 2'd1, 1'b1));
        rst_n = 1'b1;
        code  = {codes[3], codes[2], codes[1], codes[0]};
        req   = 4'b1111;
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));
        for (int r = 0; r < 5; r++) begin
            if (r == 4) req = 4'b0000;
            frame(r % 4, codes[r % 4]);
            cycle(mk(4'd0, 1'b0, 2'(r % 4), 1'b0));
        end

        // Heartbeat freeze across a frame granted with counter at 2
        hb_en = 1'b1; hb_div = 16'd3;
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));
        req = 4'b0100;
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));
        req = 4'b0000;
        frame(2, codes[2]);
        for (int i = 5; i >= 0; i--) begin
            if (i == 0) hb_en = 1'b0;
            cycle(mk(4'd0, 1'b0, 2'd2, frz[i]));
        end

        // Reset during DATA bit 3 with requests held; restart must grant 0
        req = 4'b0011;
        cycle(mk(4'd0, 1'b0, 2'd2, 1'b0));
        cycle(mk(4'b0001, 1'b1, 2'd0, 1'b1));
        cycle(mk(4'd0, 1'b1, 2'd0, 1'b1));
        cycle(mk(4'd0, 1'b1, 2'd0, 1'b0));
        cycle(mk(4'd0, 1'b1, 2'd0, 1'b0));
        rst_n = 1'b0;
        cycle(mk(4'd0, 1'b1, 2'd0, 1'b0));
        rst_n = 1'b1;
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));
        req = 4'b0000;
        frame(0, codes[0]);
        cycle(mk(4'd0, 1'b0, 2'd0, 1'b0));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
